// File: rtl/serial_frame_receiver_if.sv
// Parallel word handshake and error pulses of the serial frame receiver.
// master drives word/valid/errors; slave drives data_ready.
interface serial_frame_receiver_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output data_ready
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Start/stop framed serial receiver with one-deep valid/ready output.
// Optional even parity bit after the data bits: define SFR_PARITY_EN.
module serial_frame_receiver #(
    parameter int DATA_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    shift_in,
    serial_frame_receiver_if.master word
);
    localparam int CW = $clog2(DATA_W + 1);

`ifdef SFR_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              can_load;

`ifdef SFR_PARITY_EN
    logic par_acc;
    logic par_bad;
`else
    assign word.parity_err = 1'b0;
`endif

    // A held word may be replaced in the same cycle it is consumed.
    assign can_load = !word.data_valid || word.data_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            shreg           <= '0;
            word.data_out   <= '0;
            word.data_valid <= 1'b0;
            word.frame_err  <= 1'b0;
            word.overrun    <= 1'b0;
`ifdef SFR_PARITY_EN
            word.parity_err <= 1'b0;
            par_acc         <= 1'b0;
            par_bad         <= 1'b0;
`endif
        end else begin
            word.frame_err <= 1'b0;
            word.overrun   <= 1'b0;
`ifdef SFR_PARITY_EN
            word.parity_err <= 1'b0;
`endif
            if (word.data_valid && word.data_ready)
                word.data_valid <= 1'b0;

            if (clken) begin
                unique case (state)
                    IDLE: begin
                        if (!shift_in) begin
                            state <= DATA;
                            cnt   <= '0;
`ifdef SFR_PARITY_EN
                            par_acc <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        shreg <= (shreg << 1) | DATA_W'(shift_in);
                        cnt   <= cnt + CW'(1);
`ifdef SFR_PARITY_EN
                        par_acc <= par_acc ^ shift_in;
                        if (cnt == CW'(DATA_W - 1))
                            state <= PARITY;
`else
                        if (cnt == CW'(DATA_W - 1))
                            state <= STOP;
`endif
                    end
`ifdef SFR_PARITY_EN
                    PARITY: begin
                        par_bad <= par_acc ^ shift_in;
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        // Framing error outranks parity error.
                        if (!shift_in)
                            word.frame_err <= 1'b1;
`ifdef SFR_PARITY_EN
                        else if (par_bad)
                            word.parity_err <= 1'b1;
`endif
                        else if (can_load) begin
                            word.data_out   <= shreg;
                            word.data_valid <= 1'b1;
                        end else
                            word.overrun <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver (DATA_W = 4).
// Stimulus pushes expected words; a monitor pops them on handshakes.
module tb_serial_frame_receiver;
    logic clk = 1'b0;
    logic reset;
    logic clken;
    logic shift_in;

    serial_frame_receiver_if #(.DATA_W(4)) bus ();

    serial_frame_receiver #(.DATA_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .shift_in (shift_in),
        .word     (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    int exp_perr = 0;
    int got_ferr = 0;
    int got_ovr = 0;
    int got_perr = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit, then gap-1 unstrobed cycles with the line inverted.
    task automatic send_bit(input logic b, input int gap);
        clken    = 1'b1;
        shift_in = b;
        tick();
        clken    = 1'b0;
        shift_in = ~b;
        repeat (gap - 1) tick();
    endtask

    task automatic send_data(input logic [3:0] w, input int gap);
        for (int i = 3; i >= 0; i--)
            send_bit(w[i], gap);
    endtask

    // Monitor: consumes expected words and tallies error pulses.
    initial begin
        logic pf, po, pp;
        pf = 1'b0;
        po = 1'b0;
        pp = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.data_valid && bus.data_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL word: got %h want none",
                                 bus.data_out);
                    end else
                        check("word", bus.data_out,
                              exp_q.pop_front());
                end
                if (bus.frame_err) begin
                    got_ferr++;
                    check("ferr_width", {pf, 1'b1}, 2'b01);
                end
                if (bus.overrun) begin
                    got_ovr++;
                    check("ovr_width", {po, 1'b1}, 2'b01);
                end
                if (bus.parity_err) begin
                    got_perr++;
                    check("perr_width", {pp, 1'b1}, 2'b01);
                end
            end
            pf = bus.frame_err;
            po = bus.overrun;
            pp = bus.parity_err;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        clken          = 1'b0;
        shift_in       = 1'b1;
        bus.data_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.data_valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovr", bus.overrun, 0);
        check("rst_perr", bus.parity_err, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Basic frame, clken every cycle, consumer stalled.
        send_bit(1'b0, 1);
        send_data(4'b1011, 1);
        check("t1_pre_valid", bus.data_valid, 0);
        exp_q.push_back(4'b1011);
        send_bit(1'b1, 1);
        check("t1_valid", bus.data_valid, 1);
        check("t1_data", bus.data_out, 4'b1011);
        bus.data_ready = 1'b1;
        tick();
        check("t1_clear", bus.data_valid, 0);

        // Strobe every 3rd cycle; line toggles off-strobe.
        send_bit(1'b0, 3);
        send_data(4'b1011, 3);
        check("t2_pre_valid", bus.data_valid, 0);
        exp_q.push_back(4'b1011);
        send_bit(1'b1, 1);
        check("t2_valid", bus.data_valid, 1);
        check("t2_data", bus.data_out, 4'b1011);
        repeat (2) tick();

        // Bad stop bit, then back-to-back good frame.
        send_bit(1'b0, 1);
        send_data(4'b0110, 1);
        exp_ferr++;
        send_bit(1'b0, 1);
        check("t3_ferr", bus.frame_err, 1);
        check("t3_valid", bus.data_valid, 0);
        send_bit(1'b0, 1);
        check("t3_ferr_low", bus.frame_err, 0);
        send_data(4'b1111, 1);
        exp_q.push_back(4'b1111);
        send_bit(1'b1, 1);
        check("t3_data", bus.data_out, 4'b1111);
        repeat (2) tick();

        // Overrun: second word dropped while first is held.
        bus.data_ready = 1'b0;
        send_bit(1'b0, 1);
        send_data(4'b1010, 1);
        exp_q.push_back(4'b1010);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_data(4'b0110, 1);
        exp_ovr++;
        send_bit(1'b1, 1);
        check("t4_ovr", bus.overrun, 1);
        check("t4_hold", bus.data_out, 4'b1010);
        check("t4_valid", bus.data_valid, 1);
        tick();
        check("t4_ovr_low", bus.overrun, 0);
        check("t4_hold2", bus.data_out, 4'b1010);
        bus.data_ready = 1'b1;
        tick();
        check("t4_clear", bus.data_valid, 0);

        // Consume and reload in the same stop cycle.
        bus.data_ready = 1'b0;
        send_bit(1'b0, 1);
        send_data(4'b1010, 1);
        exp_q.push_back(4'b1010);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_data(4'b0110, 1);
        bus.data_ready = 1'b1;
        exp_q.push_back(4'b0110);
        send_bit(1'b1, 1);
        check("t4b_valid", bus.data_valid, 1);
        check("t4b_data", bus.data_out, 4'b0110);
        check("t4b_no_ovr", bus.overrun, 0);
        tick();
        check("t4b_clear", bus.data_valid, 0);

        // Async reset mid-frame, then a clean frame.
        send_bit(1'b0, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_data", bus.data_out, 0);
        check("t5_valid", bus.data_valid, 0);
        check("t5_ferr", bus.frame_err, 0);
        shift_in = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_bit(1'b0, 1);
        send_data(4'b0011, 1);
        exp_q.push_back(4'b0011);
        send_bit(1'b1, 1);
        check("t5_word", bus.data_out, 4'b0011);
        repeat (2) tick();

`ifdef SFR_PARITY_EN
        send_bit(1'b0, 1);
        send_data(4'b1011, 1);
        send_bit(1'b1, 1);
        exp_q.push_back(4'b1011);
        send_bit(1'b1, 1);
        check("p1_valid", bus.data_valid, 1);
        repeat (2) tick();

        send_bit(1'b0, 1);
        send_data(4'b1011, 1);
        send_bit(1'b0, 1);
        exp_perr++;
        send_bit(1'b1, 1);
        check("p2_perr", bus.parity_err, 1);
        check("p2_valid", bus.data_valid, 0);
        repeat (2) tick();

        send_bit(1'b0, 1);
        send_data(4'b1011, 1);
        send_bit(1'b0, 1);
        exp_ferr++;
        send_bit(1'b0, 1);
        check("p3_ferr", bus.frame_err, 1);
        check("p3_perr", bus.parity_err, 0);
        repeat (2) tick();
`endif

        shift_in = 1'b1;
        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        check("ferr_count", got_ferr, exp_ferr);
        check("ovr_count", got_ovr, exp_ovr);
        check("perr_count", got_perr, exp_perr);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
Downstream consumer of the bit-serial shift stage. Samples the serial line on bit-strobe cycles, recognises start/stop framing, and assembles DATA_W data bits into a parallel word. Each completed word is presented on a one-deep output register with a valid/ready handshake to the next stage. Malformed frames and dropped words are reported as error pulses.

Parameters:
DATA_W, 4, data bits per frame and output word width; legal range 1..32.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
clken  input  1  bit strobe; shift_in is sampled only on cycles with clken=1
shift_in  input  1  serial line; idles high
data_out  output  DATA_W  assembled word; first received data bit lands in data_out[DATA_W-1] (MSB-first)
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts the word on a cycle with data_valid=1
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  one-cycle pulse: good word dropped because output register was full
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without the optional feature)

Behaviour:
- Reset (async, active-high): state IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, frame_err/overrun/parity_err 0. Reset mid-frame aborts the frame; no partial word is ever presented.
- Single clock domain. FSM states IDLE, DATA, PARITY (feature only), STOP. All FSM and shift activity advances only on clken=1 cycles; with clken=0 the FSM, counter and shift register hold.
- IDLE: on clken with shift_in=0 (start bit), go to DATA, counter <= 0. shift_in=1 stays IDLE.
- DATA: each clken shifts the register left, inserting shift_in at bit 0; counter increments. After the DATA_W-th data bit, go to STOP (or PARITY with the feature).
- STOP, on clken:
  - shift_in=1 and (data_valid=0 or data_ready=1 this cycle): data_out <= assembled word; data_valid=1 from the next cycle.
  - shift_in=1, data_valid=1 and data_ready=0: word dropped, held word unchanged, overrun pulses 1 cycle.
  - shift_in=0: word discarded, frame_err pulses 1 cycle, data_out/data_valid unchanged.
  - In all cases return to IDLE; the next start bit is recognised on the following clken at the earliest.
- Latency: data_valid rises on the clk edge at the end of the stop-bit clken cycle (1 cycle after the stop bit is sampled).
- Handshake: data_valid and data_out hold stable until a cycle with data_ready=1. On such a cycle data_valid clears next cycle unless a new word loads in that same cycle, in which case data_valid stays 1 and data_out updates. data_ready with data_valid=0 has no effect.
- Error pulses are registered, high for exactly one clk cycle, independent of clken width.
- Counter width: clog2(DATA_W+1); no wrap-around, since the counter resets on every start bit.

Optional Feature:
Macro SFR_PARITY_EN. Defined: FSM inserts a PARITY state after DATA. The bit sampled on the next clken must make the XOR of the DATA_W data bits and the parity bit equal 0 (even parity). On mismatch, the STOP state discards the word and pulses parity_err; if the stop bit is also 0, frame_err takes priority and parity_err stays 0. Not defined: no PARITY state, frame is start + DATA_W + stop, parity_err tied 0.

Test Plan:
- Reset then clken every cycle; line bits 0,1,0,1,1,1 (start, data 1011, stop) -> data_valid=1 one cycle after stop, data_out=4'b1011; data_ready=1 -> data_valid=0 next cycle.
- Same frame with clken high only every 3rd cycle, data_ready=1 -> identical result, valid rises 1 cycle after the stop-bit strobe.
- Frame 0,0,1,1,0 then stop=0 -> frame_err single pulse, data_valid stays 0; next frame 0,1,1,1,1,1 -> data_out=4'b1111.
- data_ready=0; send 1010 then 0110 -> data_out=4'b1010 held, overrun pulses at second stop; data_ready=1 in the stop cycle of the second frame instead -> data_out=4'b0110, data_valid stays 1.
- Assert reset after 2 data bits -> all outputs 0; resume with full frame 0,0,0,1,1,1 -> data_out=4'b0011.
- SFR_PARITY_EN: data 1011, parity 1 -> word accepted; parity 0 -> parity_err pulse, no valid; parity 0 with stop 0 -> frame_err only.
